// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: fetch FSM states,
// instruction size constants and PC helpers.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [1:0]  OPCODE_LSB_RV32  = 2'b11;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] pc_next(
    input logic [31:0] pc
  );
    return pc + 32'(INSTR_BYTES);
  endfunction

  function automatic logic [31:0] pc_align(
    input logic [31:0] pc
  );
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage. Owns the PC, issues one
// word-aligned imem read at a time and hands the word to decode.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   imem_req_valid/ready, imem_addr   request channel
//   imem_rsp_valid/data               response (valid only)
//   instr_valid/ready, instr, instr_pc, instr_illegal  to decode
//   redirect_valid, redirect_pc       PC load from execute
// Option: define FETCH_ILLEGAL_CHECK_EN to flag words whose
// low two bits are not 2'b11; otherwise instr_illegal is 0.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_illegal,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         req_valid_q, req_valid_d;
  logic         ivalid_q, ivalid_d;
  logic         fire;
  logic         capture;

  // req_valid_q is only ever high in S_REQ
  assign fire = req_valid_q & imem_req_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    capture = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = pc_align(redirect_pc);
          // an accepted request still owes a response
          state_d = fire ? S_DRAIN : S_REQ;
        end else if (fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = pc_align(redirect_pc);
          state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          capture = 1'b1;
          instr_d = imem_rsp_data;
          ipc_d   = pc_q;
          pc_d    = pc_next(pc_q);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = pc_align(redirect_pc);
          state_d = S_REQ;
        end else if (instr_ready) begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          pc_d = pc_align(redirect_pc);
        end
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    req_valid_d = (state_d == S_REQ);
    ivalid_d    = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      ipc_q       <= '0;
      req_valid_q <= 1'b0;
      ivalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      req_valid_q <= req_valid_d;
      ivalid_q    <= ivalid_d;
    end
  end

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic ill_q, ill_d;

  always_comb begin
    ill_d = ill_q;
    if (capture) begin
      ill_d = (imem_rsp_data[1:0] != OPCODE_LSB_RV32);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q <= 1'b0;
    end else begin
      ill_q <= ill_d;
    end
  end

  assign instr_illegal = ill_q;
`else
  assign instr_illegal = 1'b0;
`endif

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = ivalid_q;
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table of normal fetches plus
// hand-written stall, redirect, wrap and reset sequences.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int total;
  int bad;

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_illegal  (instr_illegal),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        ill;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic exp_ill(input logic [31:0] d);
`ifdef FETCH_ILLEGAL_CHECK_EN
    return d[1:0] != 2'b11;
`else
    return 1'b0 & d[0];
`endif
  endfunction

  // Entered at a negedge with the FSM in REQ at address a.
  task automatic fetch_one(input logic [31:0] d,
                           input logic [31:0] a,
                           input logic ill,
                           input int hold);
    chk("req_valid", 32'(imem_req_valid), 32'd1);
    chk("req_addr", imem_addr, a);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait_ivalid", 32'(instr_valid), 32'd0);
    chk("wait_reqv", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    chk("ivalid", 32'(instr_valid), 32'd1);
    chk("instr", instr, d);
    chk("instr_pc", instr_pc, a);
    chk("illegal", 32'(instr_illegal), 32'(ill));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ivalid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, d);
      chk("hold_pc", instr_pc, a);
      chk("hold_noreq", 32'(imem_req_valid), 32'd0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("post_ivalid", 32'(instr_valid), 32'd0);
    chk("post_reqv", 32'(imem_req_valid), 32'd1);
    chk("post_addr", imem_addr, a + 32'd4);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{32'h0050_0093, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'h0000_0001, 32'h0000_0104, exp_ill(32'h1)};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0108, 1'b0};
    vecs[3] = '{32'h1234_5672, 32'h0000_010C,
                exp_ill(32'h2)};

    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    chk("rst_reqv", 32'(imem_req_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_ill", 32'(instr_illegal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      fetch_one(vecs[i].data, vecs[i].addr, vecs[i].ill, 0);
    end

    // decoder stalls 5 cycles
    fetch_one(32'h0000_0013, 32'h110, 1'b0, 5);

    // redirect in WAIT, late response is drained
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_reqv", 32'(imem_req_valid), 32'd0);
      chk("drain_ivalid", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("drain_done_iv", 32'(instr_valid), 32'd0);
    chk("drain_done_rv", 32'(imem_req_valid), 32'd1);
    chk("drain_addr", imem_addr, 32'h200);
    fetch_one(32'h0010_0113, 32'h200, 1'b0, 0);

    // redirect coincident with response in WAIT
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h301;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("rdrsp_ivalid", 32'(instr_valid), 32'd0);
    chk("rdrsp_reqv", 32'(imem_req_valid), 32'd1);
    chk("rdrsp_addr", imem_addr, 32'h300);
    fetch_one(32'h0020_0193, 32'h300, 1'b0, 0);

    // redirect in REQ before acceptance, then PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rdreq_reqv", 32'(imem_req_valid), 32'd1);
    chk("rdreq_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'h0000_0073, 32'hFFFF_FFFC, 1'b0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    fetch_one(32'h0000_0033, 32'h0, 1'b0, 0);

    // redirect in HOLD together with consume
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0040_0213;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("rdhold_iv", 32'(instr_valid), 32'd1);
    chk("rdhold_pc", instr_pc, 32'h4);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    @(negedge clk);
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    chk("rdhold_iv2", 32'(instr_valid), 32'd0);
    chk("rdhold_reqv", 32'(imem_req_valid), 32'd1);
    chk("rdhold_addr", imem_addr, 32'h400);

    // reset in WAIT, stray response after release ignored
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_reqv", 32'(imem_req_valid), 32'd0);
    chk("mrst_addr", imem_addr, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1113;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("mrst_iv", 32'(instr_valid), 32'd0);
    chk("mrst_reqv2", 32'(imem_req_valid), 32'd1);
    fetch_one(32'h0050_0093, 32'h100, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
